// File: rtl/goal_floor.sv
// Elevator goal-floor selector.
// While the car is stopped at a valid floor with at least one request lamp lit,
// the next goal floor is chosen and registered on gf. Otherwise the previous goal is held.
module goal_floor #(
   parameter logic [1:0] labelF1 = 2'b00,
   parameter logic [1:0] labelF2 = 2'b01,
   parameter logic [1:0] labelF3 = 2'b10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] floor,
   input  logic       led1,
   input  logic       led2,
   input  logic       led3,
   input  logic       moving,
   output logic [1:0] gf
);

   // Floor position 1..3; 0 marks a code that matches none of the labels.
   // Positions are used for distance so that non-default label codes work.
   function automatic logic [1:0] floor_index(input logic [1:0] code);
      logic [1:0] idx;
      idx = 2'd0;
      if (code == labelF1)
         idx = 2'd1;
      else if (code == labelF2)
         idx = 2'd2;
      else if (code == labelF3)
         idx = 2'd3;
      return idx;
   endfunction

   // Pick the target position: the current floor first, then the nearest lit floor.
   // At F2 with F1 and F3 both lit, the lower floor wins the tie.
   // The caller guarantees that at least one lamp is lit.
   function automatic logic [1:0] select_index(input logic [1:0] idx,
                                               input logic       l1,
                                               input logic       l2,
                                               input logic       l3);
      logic [1:0] sel;
      sel = idx;
      case (idx)
         2'd1:    sel = l1 ? 2'd1 : (l2 ? 2'd2 : 2'd3);
         2'd2:    sel = l2 ? 2'd2 : (l1 ? 2'd1 : 2'd3);
         2'd3:    sel = l3 ? 2'd3 : (l2 ? 2'd2 : 2'd1);
         default: sel = idx;
      endcase
      return sel;
   endfunction

   // Map a floor position back to its label code.
   function automatic logic [1:0] index_label(input logic [1:0] idx);
      logic [1:0] lbl;
      case (idx)
         2'd2:    lbl = labelF2;
         2'd3:    lbl = labelF3;
         default: lbl = labelF1;
      endcase
      return lbl;
   endfunction

   logic [1:0] cur_idx;
   logic       decide;
   logic [1:0] gf_next;

   // Next-goal computation: hold unless stopped at a valid floor with a lamp lit.
   always_comb begin
      cur_idx = floor_index(floor);
      decide  = !moving && (cur_idx != 2'd0) && (led1 || led2 || led3);
      gf_next = gf;
      if (decide)
         gf_next = index_label(select_index(cur_idx, led1, led2, led3));
   end

   // Goal register: asynchronous reset to floor 1, otherwise loads the next goal each edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         gf <= labelF1;
      else
         gf <= gf_next;
   end

endmodule

// File: tb/tb_goal_floor.sv
// Directed, table-driven bench for the goal-floor selector.
module tb_goal_floor;

   logic       clk;
   logic       rst_n;
   logic [1:0] floor;
   logic       led1, led2, led3, moving;
   logic [1:0] gf;

   int n_vec;
   int n_err;

   goal_floor dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .floor  (floor),
      .led1   (led1),
      .led2   (led2),
      .led3   (led3),
      .moving (moving),
      .gf     (gf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] floor;
      logic       l1;
      logic       l2;
      logic       l3;
      logic       mv;
      logic [1:0] exp;
   } vec_t;

   localparam int NV = 21;
   vec_t tbl [NV];

   task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: gf=%b expected %b", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      floor  = v.floor;
      led1   = v.l1;
      led2   = v.l2;
      led3   = v.l3;
      moving = v.mv;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;

      // floor, led1, led2, led3, moving, expected gf after the edge
      tbl[0]  = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00}; // no lamp: reset value held
      tbl[1]  = '{2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00}; // current floor F1
      tbl[2]  = '{2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00}; // moving: hold
      tbl[3]  = '{2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01}; // at F3, led2 -> F2
      tbl[4]  = '{2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01}; // invalid floor: hold
      tbl[5]  = '{2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01}; // invalid floor: hold
      tbl[6]  = '{2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10}; // at F1, led3 only -> F3
      tbl[7]  = '{2'b01, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10}; // moving: hold
      tbl[8]  = '{2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10}; // at F3, current floor first
      tbl[9]  = '{2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00}; // at F2 tie -> lower F1
      tbl[10] = '{2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01}; // at F1, nearest F2
      tbl[11] = '{2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10}; // at F2, led3 only -> F3
      tbl[12] = '{2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00}; // at F3, led1 only -> F1
      tbl[13] = '{2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01}; // at F3, nearest F2
      tbl[14] = '{2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00}; // at F1, all lit -> F1
      tbl[15] = '{2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01}; // at F2, all lit -> F2
      tbl[16] = '{2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00}; // at F2, led1 only -> F1
      tbl[17] = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00}; // no lamp: hold
      tbl[18] = '{2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10}; // at F3, current floor
      tbl[19] = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10}; // invalid floor, all lit: hold
      tbl[20] = '{2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01}; // at F1, nearest F2

      // Reset asserted from time 0: output forced without any clock edge.
      rst_n  = 1'b0;
      floor  = 2'b00;
      led1   = 1'b0;
      led2   = 1'b0;
      led3   = 1'b0;
      moving = 1'b0;
      #1;
      check("reset_async_start", gf, 2'b00);
      repeat (2) @(posedge clk);
      #1;
      check("reset_held", gf, 2'b00);
      rst_n = 1'b1;

      // Table-driven vectors: inputs set after an edge, result checked after the next.
      for (int i = 0; i < NV; i++) begin
         drive(tbl[i]);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d", i), gf, tbl[i].exp);
      end

      // One-cycle latency: new inputs must not affect gf before the next edge.
      drive('{2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10});
      #3;
      check("latency_before_edge", gf, 2'b01);
      @(posedge clk);
      #1;
      check("latency_after_edge", gf, 2'b10);

      // Asynchronous reset between edges while a qualifying decision is presented.
      drive('{2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10});
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("reset_midcycle", gf, 2'b00);
      @(posedge clk);
      #1;
      check("reset_overrides_edge", gf, 2'b00);

      // After release with no lamp lit, the reset value holds.
      @(negedge clk);
      rst_n = 1'b1;
      drive('{2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00});
      @(posedge clk);
      #1;
      check("post_reset_hold", gf, 2'b00);

      // First qualifying edge after release updates the goal.
      drive('{2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01});
      @(posedge clk);
      #1;
      check("post_reset_first_decision", gf, 2'b01);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
